// File: rtl/xent_grad_pkg.sv
// Shared types and float helpers for the cross-entropy gradient block.
// Holds the FSM encoding, the -1.0 constant and the shared float32 add().
package xent_grad_pkg;

    typedef enum logic [1:0] {
        REC  = 2'd0,
        GRAD = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [31:0] NEG_ONE_F32 = 32'hBF800000;

    // float32 add, round-to-nearest-even; subnormals flush to zero
    function automatic logic [31:0] add(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] res;
        logic [7:0]  d;
        logic [26:0] mh;
        logic [26:0] ml;
        logic [26:0] msk;
        logic [27:0] s;
        logic [24:0] mr;
        logic [9:0]  e;
        logic [4:0]  lz;
        if (a[30:0] >= b[30:0]) begin
            hi = a;
            lo = b;
        end else begin
            hi = b;
            lo = a;
        end
        mh = (hi[30:23] == 8'd0) ? 27'd0 : {1'b1, hi[22:0], 3'b000};
        ml = (lo[30:23] == 8'd0) ? 27'd0 : {1'b1, lo[22:0], 3'b000};
        d  = hi[30:23] - lo[30:23];
        if (d > 8'd26) begin
            ml = {26'd0, |ml};
        end else begin
            msk = (27'd1 << d) - 27'd1;
            ml  = (ml >> d) | {26'd0, |(ml & msk)};
        end
        e = {2'b00, hi[30:23]};
        if (hi[31] == lo[31]) s = {1'b0, mh} + {1'b0, ml};
        else                  s = {1'b0, mh} - {1'b0, ml};
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end
        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) lz = 5'(26 - i);
        end
        s  = s << lz;
        mr = '0;
        if (s == 28'd0) begin
            res = '0;
        end else if ({5'd0, lz} >= e) begin
            res = {hi[31], 31'd0};
        end else begin
            e  = e - {5'd0, lz};
            mr = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
            if (mr[24]) begin
                mr = {1'b0, 24'h800000};
                e  = e + 10'd1;
            end
            if (e >= 10'd255) res = {hi[31], 8'hFF, 23'd0};
            else              res = {hi[31], e[7:0], mr[22:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/xent_grad_argmax_track.sv
// Running argmax over one frame of softmax outputs.
// First element seeds the tracker; later non-negative strictly larger values win.
module argmax_track
    import xent_grad_pkg::*;
#(
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 valid,
    input  logic [31:0]          x,
    input  logic [IDX_WIDTH-1:0] x_i,
    output logic [IDX_WIDTH-1:0] pred
);

    logic [31:0]          r_max;
    logic [IDX_WIDTH-1:0] r_pred;
    logic                 r_seen;
    logic                 w_take;

    assign w_take = valid && (!r_seen || (!x[31] && (x > r_max)));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_max  <= '0;
            r_pred <= '0;
            r_seen <= 1'b0;
        end else if (w_take) begin
            r_max  <= x;
            r_pred <= x_i;
            r_seen <= 1'b1;
        end
    end

    assign pred = r_pred;

endmodule

// File: rtl/xent_grad.sv
// Softmax cross-entropy gradient: collect a frame, subtract 1.0 at the label, stream it out.
// Define XENT_GRAD_STATS_EN to add saturating n_samples/n_correct counters.
module xent_grad
    import xent_grad_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          x,
    input  logic [IDX_WIDTH-1:0] x_i,
    input  logic                 i_valid,
    output logic                 o_rdy,
    input  logic [IDX_WIDTH-1:0] label,
    output logic [31:0]          y,
    output logic [IDX_WIDTH-1:0] y_i,
    output logic                 o_valid,
    input  logic                 i_rdy,
    output logic [IDX_WIDTH-1:0] pred,
    output logic                 correct,
    output logic                 pred_valid
`ifdef XENT_GRAD_STATS_EN
    ,
    output logic [15:0]          n_samples,
    output logic [15:0]          n_correct
`endif
);

    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_values [WIDTH];
    logic [IDX_WIDTH-1:0] r_label;
    logic [IDX_WIDTH-1:0] r_y_i;
    logic [IDX_WIDTH-1:0] r_pred;
    logic [31:0]          r_y;
    logic                 r_correct;
    logic [IDX_WIDTH-1:0] w_trk_pred;
    logic [IDX_WIDTH-1:0] w_nxt_i;
    logic [31:0]          w_lab_val;
    logic [31:0]          w_lab_sum;
    logic                 w_accept;
    logic                 w_in_range;
    logic                 w_last;
    logic                 w_lab_ok;
    logic                 w_correct;
    logic                 w_done;

    assign w_accept   = i_valid && (r_state == REC);
    assign w_in_range = 32'(x_i) < WIDTH;
    assign w_last     = w_accept && (x_i == LAST);
    assign w_lab_ok   = 32'(r_label) < WIDTH;
    assign w_lab_val  = w_lab_ok ? r_values[r_label] : 32'd0;
    assign w_lab_sum  = add(w_lab_val, NEG_ONE_F32);
    assign w_correct  = w_lab_ok && (w_trk_pred == r_label);
    assign w_done     = (r_state == SEND) && i_rdy && (r_y_i == LAST);
    assign w_nxt_i    = r_y_i + IDX_WIDTH'(1);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            REC:     if (w_last) w_next = GRAD;
            GRAD:    w_next = SEND;
            SEND:    if (w_done) w_next = REC;
            default: w_next = REC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= REC;
        else     r_state <= w_next;
    end

    // Probability storage survives reset; only the handshake state is discarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_accept && w_in_range) r_values[x_i] <= x;
            if ((r_state == GRAD) && w_lab_ok) r_values[r_label] <= w_lab_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_label   <= '0;
            r_y       <= '0;
            r_y_i     <= '0;
            r_pred    <= '0;
            r_correct <= 1'b0;
        end else begin
            if (w_last) r_label <= label;
            if (r_state == GRAD) begin
                r_pred    <= w_trk_pred;
                r_correct <= w_correct;
                r_y_i     <= '0;
                // label 0 is being rewritten this very edge
                r_y <= (w_lab_ok && (r_label == '0)) ? w_lab_sum : r_values[0];
            end else if ((r_state == SEND) && i_rdy && (r_y_i != LAST)) begin
                r_y_i <= w_nxt_i;
                r_y   <= r_values[w_nxt_i];
            end
        end
    end

    argmax_track #(
        .IDX_WIDTH(IDX_WIDTH)
    ) u_argmax (
        .clk  (clk),
        .rst  (rst),
        .clear(w_done),
        .valid(w_accept && w_in_range),
        .x    (x),
        .x_i  (x_i),
        .pred (w_trk_pred)
    );

    assign o_rdy      = (r_state == REC);
    assign o_valid    = (r_state == SEND);
    assign pred_valid = (r_state == GRAD);
    assign pred       = pred_valid ? w_trk_pred : r_pred;
    assign correct    = pred_valid ? w_correct : r_correct;
    assign y          = r_y;
    assign y_i        = r_y_i;

`ifdef XENT_GRAD_STATS_EN
    logic [15:0] r_n_samples;
    logic [15:0] r_n_correct;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_samples <= '0;
            r_n_correct <= '0;
        end else if (pred_valid) begin
            if (r_n_samples != 16'hFFFF) r_n_samples <= r_n_samples + 16'd1;
            if (w_correct && (r_n_correct != 16'hFFFF))
                r_n_correct <= r_n_correct + 16'd1;
        end
    end

    assign n_samples = r_n_samples;
    assign n_correct = r_n_correct;
`endif

endmodule

// File: tb/tb_xent_grad.sv
// Scoreboard bench for xent_grad (WIDTH=4) with a real-arithmetic reference model.
// Stats counters are checked when XENT_GRAD_STATS_EN is defined.
module tb_xent_grad;

    localparam int W  = 4;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   x;
    logic [IW-1:0] x_i;
    logic          i_valid;
    logic          o_rdy;
    logic [IW-1:0] label;
    logic [31:0]   y;
    logic [IW-1:0] y_i;
    logic          o_valid;
    logic          i_rdy;
    logic [IW-1:0] pred;
    logic          correct;
    logic          pred_valid;
`ifdef XENT_GRAD_STATS_EN
    logic [15:0]   n_samples;
    logic [15:0]   n_correct;
`endif

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int frames = 0;
    int frames_rst = 0;
    int corr_rst = 0;
    int rdy_mode = 0;
    int rdy_k = 0;
    bit done = 1'b0;

    logic [35:0]   q_y [$];
    logic [4:0]    q_p [$];
    logic [31:0]   mv [W];
    logic [31:0]   fx [$];
    logic [IW-1:0] fi [$];

    xent_grad #(
        .WIDTH(W),
        .IDX_WIDTH(IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .x_i       (x_i),
        .i_valid   (i_valid),
        .o_rdy     (o_rdy),
        .label     (label),
        .y         (y),
        .y_i       (y_i),
        .o_valid   (o_valid),
        .i_rdy     (i_rdy),
        .pred      (pred),
        .correct   (correct),
        .pred_valid(pred_valid)
`ifdef XENT_GRAD_STATS_EN
        ,
        .n_samples (n_samples),
        .n_correct (n_correct)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        logic [30:0] mag;
        logic        up;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e   = d[62:52] - 11'd896;
        mag = {e[7:0], d[51:29]};
        up  = (d[28:0] > 29'h10000000) ||
              ((d[28:0] == 29'h10000000) && mag[0]);
        return {d[63], mag + 31'(up)};
    endfunction

    function automatic logic [31:0] rprob();
        int unsigned r;
        logic [7:0]  e;
        r = $urandom_range(9);
        if (r == 0) return 32'd0;
        e = 8'd107 + 8'($urandom_range(19));
        return {r == 1, e, 23'($urandom)};
    endfunction

    // Argmax by the frame rule: first in-range element seeds, later
    // non-negative elements win only when strictly larger as raw bits.
    function automatic logic [IW-1:0] ref_pred();
        logic [31:0]   mx = '0;
        logic [IW-1:0] p  = '0;
        bit            seen = 1'b0;
        for (int k = 0; k < fx.size(); k++) begin
            if (32'(fi[k]) < W) begin
                if (!seen || (!fx[k][31] && fx[k] > mx)) begin
                    mx = fx[k];
                    p  = fi[k];
                    seen = 1'b1;
                end
            end
        end
        return p;
    endfunction

    task automatic send_el(input logic [31:0] xv, input logic [IW-1:0] iv,
                           input logic [IW-1:0] lb);
        bit ok = 1'b0;
        x = xv;
        x_i = iv;
        label = lb;
        i_valid = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            ok = o_rdy;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (ok) begin
            if (32'(iv) < W) mv[iv] = xv;
        end else begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=o_rdy_low want=o_rdy_high");
        end
    endtask

    task automatic finish_frame(input logic [IW-1:0] lb);
        logic [IW-1:0] p;
        bit            c;
        p = ref_pred();
        c = (32'(lb) < W) && (p == lb);
        q_p.push_back({c, p});
        if (32'(lb) < W) mv[lb] = r2f(f2r(mv[lb]) - 1.0);
        for (int k = 0; k < W; k++) q_y.push_back({IW'(k), mv[k]});
        frames++;
        frames_rst++;
        if (c) corr_rst++;
        // traffic while busy must be dropped
        repeat (2) begin
            x = $urandom;
            x_i = IW'($urandom_range(W - 1));
            i_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [IW-1:0] lb);
        for (int k = 0; k < fx.size(); k++) begin
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_el(fx[k], fi[k], lb);
        end
        finish_frame(lb);
    endtask

    task automatic set4(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        fx = '{a, b, c, d};
        fi = '{IW'(0), IW'(1), IW'(2), IW'(3)};
    endtask

    initial begin
        while (!done) begin
            @(posedge clk);
            #1;
            rdy_k++;
            if (rdy_mode == 0)      i_rdy = 1'b1;
            else if (rdy_mode == 1) i_rdy = (rdy_k % 4 == 0) || (rdy_k % 4 == 3);
            else                    i_rdy = ($urandom_range(3) != 0);
        end
    end

    initial begin
        logic [31:0]   py;
        logic [IW-1:0] pyi;
        logic [IW-1:0] lp;
        logic          lc;
        logic [35:0]   ey;
        logic [4:0]    ep;
        bit            hold;
        hold = 1'b0;
        lp = '0;
        lc = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
                lp = '0;
                lc = 1'b0;
                continue;
            end
            if (hold) begin
                chk("hold_valid", 64'(o_valid), 64'd1);
                chk("hold_y", 64'({y_i, y}), 64'({pyi, py}));
            end
            hold = o_valid && !i_rdy;
            py = y;
            pyi = y_i;
            if (pred_valid) begin
                pulses++;
                if (q_p.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pred_unexpected got=pred_valid want=none");
                end else begin
                    ep = q_p.pop_front();
                    chk("pred", 64'(pred), 64'(ep[IW-1:0]));
                    chk("correct", 64'(correct), 64'(ep[4]));
                end
                lp = pred;
                lc = correct;
            end else begin
                chk("pred_hold", 64'({pred, correct}), 64'({lp, lc}));
            end
            if (o_valid && i_rdy) begin
                if (q_y.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL y_unexpected got=%h want=none", y);
                end else begin
                    ey = q_y.pop_front();
                    chk("y_i", 64'(y_i), 64'(ey[35:32]));
                    chk("y", 64'(y), 64'(ey[31:0]));
                end
            end
        end
    end

    initial begin
        logic [IW-1:0] lb;
        logic [IW-1:0] tmp;
        int            j;
        rst = 1'b1;
        i_valid = 1'b0;
        x = '0;
        x_i = '0;
        label = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", 64'(o_rdy), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_y_i", 64'(y_i), 64'd0);
        chk("rst_pred", 64'(pred), 64'd0);
        chk("rst_correct", 64'(correct), 64'd0);
        chk("rst_pv", 64'(pred_valid), 64'd0);
        @(posedge clk);
        #1;

        set4(32'h3E800000, 32'h3F000000, 32'h3E000000, 32'h3E000000);
        send_frame(IW'(1));
        set4(32'h3E800000, 32'h3F000000, 32'h3E000000, 32'h3E000000);
        send_frame(IW'(3));
        rdy_mode = 1;
        set4(32'h3F000000, 32'h3F000000, 32'h00000000, 32'h00000000);
        send_frame(IW'(0));
        set4(rprob(), rprob(), rprob(), rprob());
        send_frame(IW'(5));

        // partial frame then reset
        send_el(32'h3F400000, IW'(0), IW'(0));
        send_el(32'h3E000000, IW'(1), IW'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        frames_rst = 0;
        corr_rst = 0;
        chk("midrst_rdy", 64'(o_rdy), 64'd1);
        chk("midrst_valid", 64'(o_valid), 64'd0);
        set4(32'h3D800000, 32'h3E000000, 32'h3F200000, 32'h3C000000);
        send_frame(IW'(2));

        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            fx.delete();
            fi.delete();
            for (int k = 0; k < W - 1; k++) fi.push_back(IW'(k));
            for (int k = W - 2; k > 0; k--) begin
                j = $urandom_range(k);
                tmp = fi[k];
                fi[k] = fi[j];
                fi[j] = tmp;
            end
            if ($urandom_range(3) == 0) fi.delete($urandom_range(W - 2));
            if ($urandom_range(2) == 0)
                fi.insert($urandom_range(fi.size()),
                          IW'(W + $urandom_range((1 << IW) - 1 - W)));
            fi.push_back(IW'(W - 1));
            for (int k = 0; k < fi.size(); k++) fx.push_back(rprob());
            j = $urandom_range(9);
            if (j < 4)       lb = ref_pred();
            else if (j == 9) lb = IW'(W + $urandom_range((1 << IW) - 1 - W));
            else             lb = IW'($urandom_range(W - 1));
            send_frame(lb);
        end

        for (int n = 0; n < 500 && q_y.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_y", 64'(q_y.size()), 64'd0);
        chk("drain_p", 64'(q_p.size()), 64'd0);
        chk("pulses", 64'(pulses), 64'(frames));
        chk("end_rdy", 64'(o_rdy), 64'd1);
`ifdef XENT_GRAD_STATS_EN
        chk("n_samples", 64'(n_samples), 64'(frames_rst));
        chk("n_correct", 64'(n_correct), 64'(corr_rst));
`endif
        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xent_grad.md
XENT_GRAD -- requirements
Module: xent_grad

Interface
REQ-001 SHALL have parameter WIDTH, default 10: number of class probabilities per frame.
REQ-002 SHALL have parameter IDX_WIDTH, default 4: width of element indices and labels.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports x (input, 32 bits) and x_i (input, IDX_WIDTH bits): a float32 probability from the upstream softmax and its index.
REQ-006 SHALL have port i_valid, input, 1 bit: x/x_i valid. Port o_rdy, output, 1 bit: block accepts x.
REQ-007 SHALL have port label, input, IDX_WIDTH bits: true class, sampled with the last element.
REQ-008 SHALL have ports y (output, 32 bits) and y_i (output, IDX_WIDTH bits): float32 gradient element and its index.
REQ-009 SHALL have port o_valid, output, 1 bit: y/y_i valid. Port i_rdy, input, 1 bit: downstream consumes y.
REQ-010 SHALL have ports pred (output, IDX_WIDTH bits), correct (output, 1 bit) and pred_valid (output, 1 bit): argmax class, pred==label flag, and a one-cycle strobe.

Function
REQ-011 SHALL implement states REC, GRAD and SEND; o_rdy = (state==REC); o_valid = (state==SEND).
REQ-012 In REC, an element SHALL be accepted when i_valid && o_rdy; it is stored at values[x_i]. x_i >= WIDTH SHALL be ignored.
REQ-013 Argmax: the first accepted element of a frame SHALL initialise max/pred. Later elements with sign bit clear SHALL replace them when their bits are unsigned-greater than max (strict, so ties keep the earlier element).
REQ-014 Accepting x_i == WIDTH-1 SHALL latch label and move to GRAD the next cycle.
REQ-015 GRAD SHALL last exactly one cycle. values[label] <= add(values[label], 32'hBF800000), i.e. p - 1.0, using the shared float add. pred_valid SHALL pulse high in this cycle. correct SHALL equal (pred==label). y SHALL load values[0] and y_i SHALL load 0.
REQ-016 label >= WIDTH SHALL leave all values unmodified and force correct=0.
REQ-017 In SEND, y/y_i SHALL hold until i_rdy is high. On i_rdy, y SHALL advance to values[y_i+1]. If i_rdy is high with y_i == WIDTH-1, the block SHALL return to REC and clear the argmax tracker.
REQ-018 pred and correct SHALL hold their values until the next GRAD cycle.
REQ-019 Latency: the first y SHALL be valid 2 cycles after the last element is accepted. Throughput is one y per cycle while i_rdy stays high.
REQ-020 i_valid arriving during GRAD or SEND SHALL be ignored; o_rdy is low then.

Reset
REQ-021 rst SHALL force state=REC and clear y, y_i, pred, correct, pred_valid and the argmax tracker to 0. o_rdy SHALL be 1 and o_valid SHALL be 0 in the cycle after rst.
REQ-022 rst asserted mid-frame or mid-SEND SHALL discard the partial frame. Contents of values SHALL NOT be cleared.

Configuration
REQ-023 With macro XENT_GRAD_STATS_EN defined, the block SHALL add output ports n_samples[15:0] and n_correct[15:0].
- n_samples increments on each pred_valid; n_correct increments on pred_valid && correct.
- Both saturate at 16'hFFFF and are cleared by rst.
REQ-024 Without XENT_GRAD_STATS_EN, these ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-025 State encodings and the constant NEG_ONE_F32 = 32'hBF800000 SHALL live in the shared header, alongside the existing add() function in arith.vh.
REQ-026 Argmax tracking SHALL be the single sub-module argmax_track, with inputs clk, rst, clear, valid, x and x_i, and output pred.

Verification
REQ-027 WIDTH=4: send [3E800000, 3F000000, 3E000000, 3E000000] with label=1 and i_rdy=1 -> y = 3E800000, BF000000, 3E000000, 3E000000 on consecutive cycles; pred=1; correct=1.
REQ-028 Same frame, label=3 -> y[3]=BF600000, others unchanged; pred=1; correct=0.
REQ-029 Tie: [3F000000, 3F000000, 0, 0] -> pred=0.
REQ-030 i_rdy toggled 1,0,0,1 during SEND -> y holds through the low cycles; no element is skipped or repeated.
REQ-031 rst asserted after 2 of 4 elements, then a full frame -> output reflects only the new frame; pred_valid pulses once.
REQ-032 With XENT_GRAD_STATS_EN: 3 frames, 2 correct -> n_samples=3, n_correct=2; a label of 5 with WIDTH=4 -> correct=0 and values unmodified.
